sram_1rw1r_wmask: RTL and testbench

- Parametrised behavioural SRAM with one read/write port (port 0) and one read-only port (port 1).
- Configurable word width, depth, write-mask granularity and read latency.
- Optional reset-driven clear sweep, and read-valid strobes on both ports.
- Used as the generic on-chip storage model for register files, FIFOs and buffers, replacing the fixed 32x512 single-port model.

---
 rtl/sram_1rw1r_wmask.sv | 155 +++++++++++++++
 tb/tb_sram_1rw1r_wmask.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw1r_wmask.sv
// Behavioural 1RW + 1R SRAM with byte-lane style write mask, optional output
// register and an optional post-reset clear sweep that gates request acceptance.
module sram_1rw1r_wmask #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  ADDR_WIDTH     = 9,
    parameter int                  WMASK_GRAN     = 8,
    parameter int                  NUM_WMASKS     = DATA_WIDTH / WMASK_GRAN,
    parameter int                  OUT_REG        = 0,
    parameter int                  CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  clk0,
    input  logic                  rst0,
    output logic                  ready0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  rvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  rvalid1
);

    typedef enum logic [1:0] {S_RESET, S_INIT, S_READY} state_e;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_addr_q;
    logic                    ready_q;

    logic [DATA_WIDTH-1:0]   mem_q [0:(1<<ADDR_WIDTH)-1];

    logic                    wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_d;
    logic [NUM_WMASKS-1:0]   wr_mask_d;
    logic [1:0]              rd_req_d;
    logic [1:0][DATA_WIDTH-1:0] rd_word_d;

    logic [1:0]              vld_q;
    logic [1:0][DATA_WIDTH-1:0] data_q;

    // Sweep writes one word per cycle; the last-address cycle also raises ready.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_INIT : S_RESET;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_RESET: begin
                    state_q <= S_READY;
                    ready_q <= 1'b1;
                end
                S_INIT: begin
                    clr_addr_q <= clr_addr_q + ADDR_ONE;
                    if (clr_addr_q == '1) begin
                        state_q <= S_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready0 = ready_q;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = addr0;
        wr_data_d = din0;
        wr_mask_d = wmask0;
        if (!rst0) begin
            if (state_q == S_INIT) begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_addr_q;
                wr_data_d = INIT_VALUE;
                wr_mask_d = '1;
            end else if (ready_q && !csb0 && !web0) begin
                wr_en_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (wr_en_d) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wr_mask_d[i])
                    mem_q[wr_addr_d][i*WMASK_GRAN +: WMASK_GRAN] <= wr_data_d[i*WMASK_GRAN +: WMASK_GRAN];
            end
        end
    end

    // Port 1 sees a same-edge port 0 write on masked-in lanes (write-first).
    always_comb begin
        rd_req_d[0]  = ready_q && !csb0 && web0;
        rd_req_d[1]  = ready_q && !csb1;
        rd_word_d[0] = mem_q[addr0];
        rd_word_d[1] = mem_q[addr1];
        if (wr_en_d && (wr_addr_d == addr1)) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wr_mask_d[i])
                    rd_word_d[1][i*WMASK_GRAN +: WMASK_GRAN] = wr_data_d[i*WMASK_GRAN +: WMASK_GRAN];
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q <= rd_req_d;
            for (int p = 0; p < 2; p++) begin
                if (rd_req_d[p]) data_q[p] <= rd_word_d[p];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [1:0]                 out_vld_q;
            logic [1:0][DATA_WIDTH-1:0] out_data_q;

            always_ff @(posedge clk0) begin
                if (rst0) begin
                    out_vld_q  <= '0;
                    out_data_q <= '0;
                end else begin
                    out_vld_q <= vld_q;
                    for (int p = 0; p < 2; p++) begin
                        if (vld_q[p]) out_data_q[p] <= data_q[p];
                    end
                end
            end

            assign dout0   = out_data_q[0];
            assign dout1   = out_data_q[1];
            assign rvalid0 = out_vld_q[0];
            assign rvalid1 = out_vld_q[1];
        end else begin : g_no_out_reg
            assign dout0   = data_q[0];
            assign dout1   = data_q[1];
            assign rvalid0 = vld_q[0];
            assign rvalid1 = vld_q[1];
        end
    endgenerate

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed bench: two instances (1-cycle and 2-cycle read latency) share all
// inputs, so every scenario is checked at both latencies.
module tb_sram_1rw1r_wmask;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [3:0]  addr0, addr1;
    logic [31:0] din0;

    logic        ready_a, rvalid0_a, rvalid1_a;
    logic [31:0] dout0_a, dout1_a;
    logic        ready_b, rvalid0_b, rvalid1_b;
    logic [31:0] dout0_b, dout1_b;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_w [1:3];

    always #5 clk0 = ~clk0;

    sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_GRAN(8), .OUT_REG(0),
                       .CLEAR_ON_RESET(1), .INIT_VALUE(IV)) dut_a (
        .clk0(clk0), .rst0(rst0), .ready0(ready_a),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_a), .rvalid0(rvalid0_a),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_a), .rvalid1(rvalid1_a));

    sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_GRAN(8), .OUT_REG(1),
                       .CLEAR_ON_RESET(1), .INIT_VALUE(IV)) dut_b (
        .clk0(clk0), .rst0(rst0), .ready0(ready_b),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .dout0(dout0_b), .rvalid0(rvalid0_b),
        .csb1(csb1), .addr1(addr1), .dout1(dout1_b), .rvalid1(rvalid1_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'h0; din0 = '0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    endtask

    initial begin
        rst0 = 1'b1; addr0 = '0; addr1 = '0;
        idle();
        repeat (3) tick();
        chk("rst_ready_a", {31'b0, ready_a}, 32'd0);
        chk("rst_ready_b", {31'b0, ready_b}, 32'd0);
        chk("rst_dout0_a", dout0_a, 32'd0);
        chk("rst_dout1_b", dout1_b, 32'd0);
        chk("rst_rvalid", {28'b0, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 32'd0);

        // First sweep, interrupted after address 8 has been written.
        rst0 = 1'b0;
        csb1 = 1'b0; addr1 = 4'd0;
        repeat (9) tick();
        chk("init_ready_mid", {31'b0, ready_a}, 32'd0);
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 11) wr(4'd5, 32'h0, 4'hF);
            else begin csb0 = 1'b1; web0 = 1'b1; end
            tick();
            if (|{rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b})
                chk("init_no_rvalid", {28'b0, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 32'd0);
            if (k == 15) begin
                chk("init_ready15_a", {31'b0, ready_a}, 32'd0);
                chk("init_ready15_b", {31'b0, ready_b}, 32'd0);
            end
        end
        chk("init_ready16_a", {31'b0, ready_a}, 32'd1);
        chk("init_ready16_b", {31'b0, ready_b}, 32'd1);
        chk("init_rvalid_q", {28'b0, rvalid0_a, rvalid1_a, rvalid0_b, rvalid1_b}, 32'd0);
        idle();

        // Port 1 sweep read of all words.
        for (int i = 0; i <= 16; i++) begin
            csb1  = (i < 16) ? 1'b0 : 1'b1;
            addr1 = 4'(i);
            tick();
            if (i < 16) begin
                chk($sformatf("clr_a_%0d", i), dout1_a, IV);
                chk("clr_rv_a", {31'b0, rvalid1_a}, 32'd1);
            end else
                chk("clr_rv_a_end", {31'b0, rvalid1_a}, 32'd0);
            if (i >= 1) begin
                chk($sformatf("clr_b_%0d", i - 1), dout1_b, IV);
                chk("clr_rv_b", {31'b0, rvalid1_b}, 32'd1);
            end
        end
        idle();
        tick();
        chk("clr_rv_b_end", {31'b0, rvalid1_b}, 32'd0);

        // Masked write then read-after-write.
        wr(4'd3, 32'h11223344, 4'b1111);
        tick();
        chk("wr_no_rvalid", {30'b0, rvalid0_a, rvalid0_b}, 32'd0);
        wr(4'd3, 32'hFFFFFFFF, 4'b0101);
        tick();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
        tick();
        chk("mask_a_data", dout0_a, 32'h11FF33FF);
        chk("mask_a_rv", {31'b0, rvalid0_a}, 32'd1);
        chk("mask_b_rv_early", {31'b0, rvalid0_b}, 32'd0);
        idle();
        tick();
        chk("mask_a_rv_pulse", {31'b0, rvalid0_a}, 32'd0);
        chk("mask_a_hold", dout0_a, 32'h11FF33FF);
        chk("mask_b_data", dout0_b, 32'h11FF33FF);
        chk("mask_b_rv", {31'b0, rvalid0_b}, 32'd1);
        tick();
        chk("mask_b_rv_pulse", {31'b0, rvalid0_b}, 32'd0);
        wr(4'd5, 32'h0, 4'b0000);
        tick();
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd5;
        tick();
        chk("mask0_noop_a", dout0_a, IV);

        // Same-edge write / port 1 read collision.
        wr(4'd7, 32'h0, 4'hF);
        tick();
        wr(4'd7, 32'hDEADBEEF, 4'b0011);
        csb1 = 1'b0; addr1 = 4'd7;
        tick();
        chk("coll_a", dout1_a, 32'h0000BEEF);
        idle();
        tick();
        chk("coll_b", dout1_b, 32'h0000BEEF);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd7;
        tick();
        chk("coll_mem_a", dout0_a, 32'h0000BEEF);
        idle();

        // Back-to-back reads on both ports.
        exp_w[1] = 32'h01010101; exp_w[2] = 32'h02020202; exp_w[3] = 32'h11FF33FF;
        wr(4'd1, exp_w[1], 4'hF);
        tick();
        wr(4'd2, exp_w[2], 4'hF);
        tick();
        for (int i = 0; i <= 4; i++) begin
            if (i < 3) begin
                csb0 = 1'b0; web0 = 1'b1; addr0 = 4'(i + 1);
                csb1 = 1'b0; addr1 = 4'(3 - i);
            end else idle();
            tick();
            if (i < 3) begin
                chk($sformatf("b2b_a0_%0d", i), dout0_a, exp_w[i + 1]);
                chk($sformatf("b2b_a1_%0d", i), dout1_a, exp_w[3 - i]);
                chk("b2b_a_rv", {30'b0, rvalid0_a, rvalid1_a}, 32'd3);
            end else begin
                chk("b2b_a_rv_end", {30'b0, rvalid0_a, rvalid1_a}, 32'd0);
                chk("b2b_a_hold", {dout0_a[15:0], dout1_a[15:0]}, {exp_w[3][15:0], exp_w[1][15:0]});
            end
            if (i >= 1 && i <= 3) begin
                chk($sformatf("b2b_b0_%0d", i), dout0_b, exp_w[i]);
                chk($sformatf("b2b_b1_%0d", i), dout1_b, exp_w[4 - i]);
                chk("b2b_b_rv", {30'b0, rvalid0_b, rvalid1_b}, 32'd3);
            end else if (i == 4) begin
                chk("b2b_b_rv_end", {30'b0, rvalid0_b, rvalid1_b}, 32'd0);
                chk("b2b_b_hold0", dout0_b, exp_w[3]);
                chk("b2b_b_hold1", dout1_b, exp_w[1]);
            end
        end

        // Reset with a read in flight in the registered-output instance.
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd1;
        tick();
        chk("inflight_a_rv", {31'b0, rvalid0_a}, 32'd1);
        idle();
        rst0 = 1'b1;
        tick();
        chk("inflight_b_rv", {31'b0, rvalid0_b}, 32'd0);
        chk("inflight_b_dout", dout0_b, 32'd0);
        chk("midrst_a_dout", dout0_a, 32'd0);
        chk("midrst_ready", {30'b0, ready_a, ready_b}, 32'd0);
        rst0 = 1'b0;
        tick();
        chk("midrst_b_rv_after", {31'b0, rvalid0_b}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
